// File: rtl/dlf_ctrl_pkg.sv
// rtl/dlf_ctrl_pkg.sv - shared states, gear codes and helpers for the DLF gear/lock controller
package dlf_ctrl_pkg;

   // Controller states; encoding is visible on state_o for debug.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_ACQ    = 3'd2,
      ST_SETTLE = 3'd3,
      ST_MID    = 3'd4,
      ST_TRACK  = 3'd5
   } state_t;

   // Loop-filter coefficient set codes (3 is never driven).
   localparam logic [1:0] GEAR_WIDE   = 2'd0;
   localparam logic [1:0] GEAR_MID    = 2'd1;
   localparam logic [1:0] GEAR_NARROW = 2'd2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Gear presented for a state; SETTLE already shows the gear of the state it leads to.
   function automatic logic [1:0] gear_of(input state_t s, input state_t succ);
      logic [1:0] g;
      g = GEAR_WIDE;
      case (s)
         ST_MID:    g = GEAR_MID;
         ST_TRACK:  g = GEAR_NARROW;
         ST_SETTLE: g = (succ == ST_MID) ? GEAR_MID : GEAR_NARROW;
         default:   g = GEAR_WIDE;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/dlf_run_counter.sv
// rtl/dlf_run_counter.sv - saturating consecutive-event counter with terminal flag
module dlf_run_counter #(
   parameter int CW     = 7,
   parameter int TARGET = 64
) (
   input  logic clk,
   input  logic rstn,
   input  logic inc,
   input  logic clr,
   input  logic hold,
   output logic term
);

   localparam logic [CW-1:0] TGT = CW'(TARGET);

   logic [CW-1:0] count;

   assign term = (count == TGT);

   // clr wins, hold freezes (no sample), a non-event sample breaks the run, events saturate at TARGET.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (hold) begin
         count <= count;
      end else if (!inc) begin
         count <= '0;
      end else if (!term) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/dlf_gear_ctrl.sv
// rtl/dlf_gear_ctrl.sv - DLF bandwidth gear-shift and lock controller; optional MID gear under DLF_GEAR_MID_EN
module dlf_gear_ctrl
   import dlf_ctrl_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int LOCK_THRESH   = 4,
   parameter int UNLOCK_THRESH = 12,
   parameter int LOCK_CNT      = 64,
   parameter int UNLOCK_CNT    = 8,
   parameter int SETTLE_CYC    = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic             err_valid,
   input  logic [WIDTH-1:0] err_mag,
   output logic [1:0]       gear,
   output logic             dlf_clear,
   output logic             locked,
   output logic [2:0]       state_o
);

   localparam int CW = $clog2(max_int(LOCK_CNT, UNLOCK_CNT) + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);

   localparam logic [WIDTH-1:0] LOCK_T      = WIDTH'(LOCK_THRESH);
   localparam logic [WIDTH-1:0] UNLOCK_T    = WIDTH'(UNLOCK_THRESH);
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);

   state_t        state;
   state_t        state_n;
   state_t        succ;
   state_t        succ_n;
   logic [SW-1:0] settle_cnt;

   logic good_smp;
   logic bad_smp;
   logic good_active;
   logic bad_active;
   logic good_term;
   logic bad_term;

   // Samples between the two thresholds are neither good nor bad.
   assign good_smp = (err_mag <= LOCK_T);
   assign bad_smp  = (err_mag > UNLOCK_T);

`ifdef DLF_GEAR_MID_EN
   assign good_active = (state == ST_ACQ) || (state == ST_MID);
   assign bad_active  = (state == ST_TRACK) || (state == ST_MID);
`else
   assign good_active = (state == ST_ACQ);
   assign bad_active  = (state == ST_TRACK);
`endif

   // Counters are held at zero outside the states that use them, on disable, and once their run is consumed.
   dlf_run_counter #(
      .CW     (CW),
      .TARGET (LOCK_CNT)
   ) u_good_cnt (
      .clk  (clk),
      .rstn (rstn),
      .inc  (good_smp),
      .clr  (!enable || !good_active || good_term),
      .hold (!err_valid),
      .term (good_term)
   );

   dlf_run_counter #(
      .CW     (CW),
      .TARGET (UNLOCK_CNT)
   ) u_bad_cnt (
      .clk  (clk),
      .rstn (rstn),
      .inc  (bad_smp),
      .clr  (!enable || !bad_active || bad_term),
      .hold (!err_valid),
      .term (bad_term)
   );

   // Next-state logic: disable first, then counter terminals; SETTLE exits to its recorded successor.
   always_comb begin
      state_n = state;
      succ_n  = succ;
      if (!enable) begin
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  state_n = ST_CLEAR;
            ST_CLEAR: state_n = ST_ACQ;
            ST_ACQ: begin
               if (good_term) begin
                  state_n = ST_SETTLE;
`ifdef DLF_GEAR_MID_EN
                  succ_n  = ST_MID;
`else
                  succ_n  = ST_TRACK;
`endif
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state_n = succ;
               end
            end
`ifdef DLF_GEAR_MID_EN
            ST_MID: begin
               if (bad_term) begin
                  state_n = ST_ACQ;
               end else if (good_term) begin
                  state_n = ST_SETTLE;
                  succ_n  = ST_TRACK;
               end
            end
`endif
            ST_TRACK: begin
               if (bad_term) begin
                  state_n = ST_ACQ;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // State, successor and all outputs are registered from the next-state decision.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         succ      <= ST_TRACK;
         gear      <= GEAR_WIDE;
         locked    <= 1'b0;
         dlf_clear <= 1'b0;
      end else begin
         state     <= state_n;
         succ      <= succ_n;
         gear      <= gear_of(state_n, succ_n);
         locked    <= (state_n == ST_TRACK);
         dlf_clear <= (state_n == ST_CLEAR);
      end
   end

   // SETTLE dwell counts clocks, not samples; it restarts from zero on every entry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         settle_cnt <= '0;
      end else if ((state == ST_SETTLE) && (state_n == ST_SETTLE)) begin
         settle_cnt <= settle_cnt + SW'(1);
      end else begin
         settle_cnt <= '0;
      end
   end

   assign state_o = state;

endmodule
